sd_sector_sched: RTL

//  Sequences SD sector reads for WAV playback. Issues sector requests to the SD read engine,

---
 rtl/sd_sector_sched.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_sched.sv
// -----------------------------------------------------------------------------
// sd_sector_sched
//   Sequences SD sector reads for WAV playback. Requests sectors from the SD
//   read engine, stores the returned bytes in a 2 x SEC_BYTES ping-pong buffer
//   and serves 16-bit little-endian samples to the audio DAC feeder.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   init_done              SD card initialisation complete (level)
//   start / stop           1-cycle pulses: begin / abort playback
//   start_sec, num_sec     first sector and sector count (num_sec=0 ignored)
//   loop                   wrap to start_sec after the last sector
//   rd_req, rd_sec         sector request and sector number to the SD engine
//   rd_byte, rd_valid      byte stream from the SD engine
//   rd_done                1-cycle pulse: sector transfer finished
//   aud_rden, aud_data     sample request / registered sample (1-cycle latency)
//   busy                   1 in any state except IDLE/DONE
//   err                    sticky: retries exhausted; cleared by start
//   underrun               saturating count of reads with no full bank
// -----------------------------------------------------------------------------
module sd_sector_sched #(
   parameter int unsigned SEC_BYTES   = 512,
   parameter int unsigned TIMEOUT_CYC = 1_000_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic        start,
   input  logic        stop,
   input  logic [31:0] start_sec,
   input  logic [31:0] num_sec,
   input  logic        loop,
   output logic        rd_req,
   output logic [31:0] rd_sec,
   input  logic [7:0]  rd_byte,
   input  logic        rd_valid,
   input  logic        rd_done,
   input  logic        aud_rden,
   output logic [15:0] aud_data,
   output logic        busy,
   output logic        err,
   output logic [15:0] underrun
);

   localparam int unsigned AW = $clog2(SEC_BYTES);
   localparam int unsigned BW = $clog2(SEC_BYTES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 1);

   localparam logic [BW-1:0] BPTR_FULL = BW'(SEC_BYTES);
   localparam logic [AW-2:0] WPTR_LAST = (AW-1)'(SEC_BYTES / 2 - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RTY_LAST  = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_INIT,
      S_ISSUE,
      S_RECV,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   cur_q, cur_d;
   logic [31:0]   first_q, first_d;
   logic [31:0]   num_q, num_d;
   logic          loop_q, loop_d;
   logic [31:0]   idx_q, idx_d;
   logic [BW-1:0] bptr_q, bptr_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          got_q, got_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-2:0] wptr_q, wptr_d;
   logic [1:0]    full_q, full_d;
   logic          err_q, err_d;
   logic [15:0]   und_q, und_d;
   logic [15:0]   aud_q, aud_d;

   logic [7:0]    mem [0:2*SEC_BYTES-1];
   logic          we;
   logic [AW:0]   waddr;
   logic [7:0]    rd_lo, rd_hi;
   logic          rd_req_c;
   logic          acc;
   logic          sec_ok, sec_fail;

   assign rd_lo = mem[{rd_bank_q, wptr_q, 1'b0}];
   assign rd_hi = mem[{rd_bank_q, wptr_q, 1'b1}];

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      first_d   = first_q;
      num_d     = num_q;
      loop_d    = loop_q;
      idx_d     = idx_q;
      bptr_d    = bptr_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      got_d     = got_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wptr_d    = wptr_q;
      full_d    = full_q;
      err_d     = err_q;
      und_d     = und_q;
      aud_d     = aud_q;
      we        = 1'b0;
      waddr     = {wr_bank_q, bptr_q[AW-1:0]};
      rd_req_c  = 1'b0;
      acc       = 1'b0;
      sec_ok    = 1'b0;
      sec_fail  = 1'b0;

      // Consumer side runs in every state so full banks drain after DONE.
      if (aud_rden) begin
         if (full_q[rd_bank_q]) begin
            aud_d = {rd_hi, rd_lo};
            if (wptr_q == WPTR_LAST) begin
               full_d[rd_bank_q] = 1'b0;
               rd_bank_d         = ~rd_bank_q;
               wptr_d            = '0;
            end else begin
               wptr_d = wptr_q + 1'b1;
            end
         end else begin
            aud_d = '0;
            if (und_q != '1) und_d = und_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && (num_sec != '0)) begin
               state_d = S_WAIT_INIT;
               first_d = start_sec;
               cur_d   = start_sec;
               num_d   = num_sec;
               loop_d  = loop;
               idx_d   = '0;
               retry_d = '0;
               bptr_d  = '0;
               err_d   = 1'b0;
               und_d   = '0;
            end
         end
         S_WAIT_INIT: begin
            if (init_done) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (!full_q[wr_bank_q]) begin
               rd_req_c = 1'b1;
               state_d  = S_RECV;
               tmo_d    = '0;
               got_d    = 1'b0;
               bptr_d   = '0;
            end
         end
         S_RECV: begin
            rd_req_c = ~got_q;
            acc      = rd_valid && (bptr_q < BPTR_FULL);
            if (rd_valid) begin
               got_d = 1'b1;
               tmo_d = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
            if (acc) begin
               we     = 1'b1;
               bptr_d = bptr_q + 1'b1;
            end
            // A byte arriving together with rd_done still counts toward the sector.
            if (rd_done) begin
               sec_ok   = (bptr_d == BPTR_FULL);
               sec_fail = (bptr_d != BPTR_FULL);
            end else if (!rd_valid && (tmo_q == TMO_LAST)) begin
               sec_fail = 1'b1;
            end
            if (sec_ok) begin
               full_d[wr_bank_q] = 1'b1;
               wr_bank_d         = ~wr_bank_q;
               retry_d           = '0;
               bptr_d            = '0;
               if (idx_q == num_q - 32'd1) begin
                  if (loop_q) begin
                     cur_d   = first_q;
                     idx_d   = '0;
                     state_d = S_ISSUE;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  cur_d   = cur_q + 32'd1;
                  idx_d   = idx_q + 32'd1;
                  state_d = S_ISSUE;
               end
            end else if (sec_fail) begin
               bptr_d = '0;
               if (retry_q == RTY_LAST) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything above, including a same-cycle bank fill.
      if (stop) begin
         state_d   = S_IDLE;
         full_d    = '0;
         wr_bank_d = 1'b0;
         rd_bank_d = 1'b0;
         wptr_d    = '0;
         bptr_d    = '0;
         retry_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cur_q     <= '0;
         first_q   <= '0;
         num_q     <= '0;
         loop_q    <= 1'b0;
         idx_q     <= '0;
         bptr_q    <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         got_q     <= 1'b0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wptr_q    <= '0;
         full_q    <= '0;
         err_q     <= 1'b0;
         und_q     <= '0;
         aud_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         first_q   <= first_d;
         num_q     <= num_d;
         loop_q    <= loop_d;
         idx_q     <= idx_d;
         bptr_q    <= bptr_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         got_q     <= got_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wptr_q    <= wptr_d;
         full_q    <= full_d;
         err_q     <= err_d;
         und_q     <= und_d;
         aud_q     <= aud_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= rd_byte;
   end

   assign rd_req   = rd_req_c;
   assign rd_sec   = cur_q;
   assign aud_data = aud_q;
   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign err      = err_q;
   assign underrun = und_q;

endmodule
